conv_window_fetch: RTL and testbench

CONV_WINDOW_FETCH -- requirements
Module: conv_window_fetch

---
 rtl/conv_window_fetch.sv | 244 ++++++++++++++++++++++++
 tb/tb_conv_window_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// Fetches one channel of a ROWS x COLS byte image from a word-wide RAM into a local
// buffer, then streams every 3x3 window of that channel with a valid/ready handshake.
module conv_window_fetch #(
    parameter int BAND     = 64,
    parameter int DEPTH    = 1024,
    parameter int COLS     = 18,
    parameter int ROWS     = 3,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        ram_rd,
    output logic [$clog2(DEPTH)-1:0]    ram_addr,
    input  logic [BAND-1:0]             ram_data,
    input  logic                        ram_data_valid,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [71:0]                 win_data,
    output logic [$clog2(CHANNELS)-1:0] win_ch,
    output logic [$clog2(COLS)-1:0]     win_col,
    output logic                        busy,
    output logic                        done
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CHW      = $clog2(CHANNELS);
    localparam int COLW     = $clog2(COLS);
    localparam int CH_BYTES = ROWS * COLS;
    localparam int NBUF     = (CH_BYTES + 14) / 8;
    localparam int KW       = $clog2(NBUF + 1);
    localparam int BW       = AW + 3;
    localparam int FLAT_W   = NBUF * BAND;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        EMIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    c_q, c_d;
    logic [COLW-1:0]   oc_q, oc_d;
    logic [KW-1:0]     k_q, k_d;
    logic [KW-1:0]     nlast_q, nlast_d;
    logic [2:0]        off_q, off_d;
    logic [AW-1:0]     last_q, last_d;
    logic [AW-1:0]     ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              win_valid_q, win_valid_d;
    logic [71:0]       win_data_q, win_data_d;
    logic [CHW-1:0]    win_ch_q, win_ch_d;
    logic [COLW-1:0]   win_col_q, win_col_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BAND-1:0]   buf_q [NBUF];
    logic [BAND-1:0]   buf_d [NBUF];

    logic              fetch_go;
    logic [BW-1:0]     base_v;
    logic [FLAT_W-1:0] flat_v;
    int                idx;

    // Byte address of the first byte of channel ch.
    function automatic logic [BW-1:0] chan_base(input logic [CHW-1:0] ch);
        return BW'(ch) * BW'(CH_BYTES);
    endfunction

    // Next-state, counters, buffer capture and next output values.
    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        oc_d       = oc_q;
        k_d        = k_q;
        nlast_d    = nlast_q;
        off_d      = off_q;
        last_d     = last_q;
        ram_addr_d = ram_addr_q;
        buf_d      = buf_q;
        fetch_go   = 1'b0;
        base_v     = '0;
        flat_v     = '0;
        idx        = 0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d      = '0;
                    fetch_go = 1'b1;
                    state_d  = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (ram_addr_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    ram_addr_d = ram_addr_q + AW'(1);
                end
            end
            DRAIN: begin
                // The final read returns one cycle after FETCH ends.
                if (ram_data_valid && (k_q == nlast_q)) begin
                    oc_d    = '0;
                    off_d   = 3'(chan_base(c_q));
                    state_d = EMIT;
                end else begin
                    state_d = DRAIN;
                end
            end
            EMIT: begin
                if (win_ready) begin
                    if (oc_q == COLW'(COLS - 3)) begin
                        if (c_q == CHW'(CHANNELS - 1)) begin
                            state_d = FIN;
                        end else begin
                            c_d      = c_q + CHW'(1);
                            fetch_go = 1'b1;
                            state_d  = FETCH;
                        end
                    end else begin
                        oc_d = oc_q + COLW'(1);
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (((state_q == FETCH) || (state_q == DRAIN)) && ram_data_valid) begin
            for (int i = 0; i < NBUF; i++) begin
                if (k_q == KW'(i)) begin
                    buf_d[i] = ram_data;
                end else begin
                    buf_d[i] = buf_d[i];
                end
            end
            k_d = k_q + KW'(1);
        end else begin
            k_d = k_d;
        end

        if (fetch_go) begin
            base_v     = chan_base(c_d);
            k_d        = '0;
            ram_addr_d = AW'(base_v >> 3);
            last_d     = AW'((base_v + BW'(CH_BYTES - 1)) >> 3);
            nlast_d    = KW'(last_d - ram_addr_d);
        end else begin
            base_v = '0;
        end

        // Window is built from the post-capture buffer so it is ready on EMIT entry.
        for (int i = 0; i < NBUF; i++) begin
            flat_v[i*BAND +: BAND] = buf_d[i];
        end
        win_data_d = '0;
        if (state_d == EMIT) begin
            for (int r = 0; r < 3; r++) begin
                for (int kk = 0; kk < 3; kk++) begin
                    idx = int'(off_d) + r * COLS + int'(oc_d) + kk;
                    win_data_d[(r*3+kk)*8 +: 8] = 8'(flat_v >> (idx * 8));
                end
            end
        end else begin
            win_data_d = '0;
        end

        ram_rd_d    = (state_d == FETCH);
        if (state_d != FETCH) begin
            ram_addr_d = '0;
        end else begin
            ram_addr_d = ram_addr_d;
        end
        win_valid_d = (state_d == EMIT);
        win_ch_d    = (state_d == EMIT) ? c_d : '0;
        win_col_d   = (state_d == EMIT) ? oc_d : '0;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FIN);
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            oc_q        <= '0;
            k_q         <= '0;
            nlast_q     <= '0;
            off_q       <= 3'd0;
            last_q      <= '0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            win_valid_q <= 1'b0;
            win_data_q  <= 72'd0;
            win_ch_q    <= '0;
            win_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            oc_q        <= oc_d;
            k_q         <= k_d;
            nlast_q     <= nlast_d;
            off_q       <= off_d;
            last_q      <= last_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_ch_q    <= win_ch_d;
            win_col_q   <= win_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Line buffer storage; contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBUF; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

    assign ram_rd    = ram_rd_q;
    assign ram_addr  = ram_addr_q;
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_ch    = win_ch_q;
    assign win_col   = win_col_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch: two instances (COLS=18 and COLS=33) with RAM models
// preloaded so that every byte equals its column index.
module tb_conv_window_fetch;

    typedef struct {
        logic [71:0] data;
        int          ch;
        int          col;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, rd_a, rvalid_a = 1'b0, wv_a, wr_a = 1'b1, busy_a, done_a;
    logic [9:0]  addr_a;
    logic [63:0] rdata_a = 64'd0;
    logic [71:0] wd_a;
    logic [1:0]  wch_a;
    logic [4:0]  wcol_a;

    logic        start_b = 1'b0, rd_b, rvalid_b = 1'b0, wv_b, wr_b = 1'b1, busy_b, done_b;
    logic [9:0]  addr_b;
    logic [63:0] rdata_b = 64'd0;
    logic [71:0] wd_b;
    logic [1:0]  wch_b;
    logic [5:0]  wcol_b;

    logic [63:0] mem_a [1024];
    logic [63:0] mem_b [1024];

    win_t ew_a[$], ew_b[$];
    int   ea_a[$], ea_b[$];
    int   n_cmp = 0, n_bad = 0;
    int   hs_a = 0, hs_b = 0, dn_a = 0, dn_b = 0;

    conv_window_fetch #(.COLS(18)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .ram_rd(rd_a), .ram_addr(addr_a),
        .ram_data(rdata_a), .ram_data_valid(rvalid_a), .win_valid(wv_a), .win_ready(wr_a),
        .win_data(wd_a), .win_ch(wch_a), .win_col(wcol_a), .busy(busy_a), .done(done_a)
    );

    conv_window_fetch #(.COLS(33)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .ram_rd(rd_b), .ram_addr(addr_b),
        .ram_data(rdata_b), .ram_data_valid(rvalid_b), .win_valid(wv_b), .win_ready(wr_b),
        .win_data(wd_b), .win_ch(wch_b), .win_col(wcol_b), .busy(busy_b), .done(done_b)
    );

    // RAM models: data one cycle after the read strobe.
    always @(posedge clk) begin
        rvalid_a <= rd_a;
        rdata_a  <= mem_a[addr_a];
        rvalid_b <= rd_b;
        rdata_b  <= mem_b[addr_b];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event or timeout", name);
    endtask

    function automatic logic [71:0] exp_win(input int oc);
        logic [23:0] row;
        row = {8'(oc + 2), 8'(oc + 1), 8'(oc)};
        return {row, row, row};
    endfunction

    task automatic push_frame(input int cols, input bit sel);
        win_t w;
        for (int c = 0; c < 4; c++) begin
            for (int a = (c * 3 * cols) / 8; a <= (c * 3 * cols + 3 * cols - 1) / 8; a++) begin
                if (sel) ea_b.push_back(a);
                else     ea_a.push_back(a);
            end
            for (int oc = 0; oc < cols - 2; oc++) begin
                w.data = exp_win(oc);
                w.ch   = c;
                w.col  = oc;
                if (sel) ew_b.push_back(w);
                else     ew_a.push_back(w);
            end
        end
    endtask

    // Monitor for instance A: read addresses, windows (every valid cycle), done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_a) begin
                if (ea_a.size() == 0) flag("a_extra_read");
                else check("a_ram_addr", 128'(addr_a), 128'(ea_a.pop_front()));
            end
            if (wv_a) begin
                if (ew_a.size() == 0) flag("a_extra_window");
                else begin
                    check("a_win_data", 128'(wd_a), 128'(ew_a[0].data));
                    check("a_win_ch", 128'(wch_a), 128'(ew_a[0].ch));
                    check("a_win_col", 128'(wcol_a), 128'(ew_a[0].col));
                    if (wr_a) begin
                        void'(ew_a.pop_front());
                        hs_a++;
                    end
                end
            end
            if (done_a) dn_a++;
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_b) begin
                if (ea_b.size() == 0) flag("b_extra_read");
                else check("b_ram_addr", 128'(addr_b), 128'(ea_b.pop_front()));
            end
            if (wv_b) begin
                if (ew_b.size() == 0) flag("b_extra_window");
                else begin
                    check("b_win_data", 128'(wd_b), 128'(ew_b[0].data));
                    check("b_win_ch", 128'(wch_b), 128'(ew_b[0].ch));
                    check("b_win_col", 128'(wcol_b), 128'(ew_b[0].col));
                    if (wr_b) begin
                        void'(ew_b.pop_front());
                        hs_b++;
                    end
                end
            end
            if (done_b) dn_b++;
        end
    end

    task automatic wait_done(input bit sel, input int d0);
        int t;
        t = 0;
        while (((sel ? dn_b : dn_a) == d0) && (t < 3000)) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) flag(sel ? "b_done_timeout" : "a_done_timeout");
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_a(input int ch, input int col);
        int t;
        t = 0;
        while (!(wv_a && (int'(wch_a) == ch) && (col < 0 || int'(wcol_a) == col)) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin
        int d0, h0, t;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 64'd0;
            mem_b[i] = 64'd0;
        end
        for (int b = 0; b < 4 * 54; b++) mem_a[b / 8][(b % 8) * 8 +: 8] = 8'(b % 18);
        for (int b = 0; b < 4 * 99; b++) mem_b[b / 8][(b % 8) * 8 +: 8] = 8'(b % 33);

        #3;
        check("reset_outputs", 128'({rd_a, addr_a, wv_a, wd_a, wch_a, wcol_a, busy_a, done_a}), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", 128'({busy_a, rd_a}), 128'd0);

        // Full frame with a 5-cycle stall on column 3 and a start pulse while busy.
        push_frame(18, 1'b0);
        d0 = dn_a;
        h0 = hs_a;
        pulse_start(1'b0);
        wait_a(0, -1);
        check("first_win_data", 128'(wd_a), 128'(72'h020100020100020100));
        check("first_win_pos", 128'({wch_a, wcol_a}), 128'd0);
        wait_a(0, 3);
        wr_a = 1'b0;
        check("stall_win_data_0", 128'(wd_a), 128'(72'h050403050403050403));
        pulse_start(1'b0);
        repeat (4) @(posedge clk);
        #1 check("stall_win_data_5", 128'(wd_a), 128'(72'h050403050403050403));
        wr_a = 1'b1;
        wait_done(1'b0, d0);
        check("frame_windows", 128'(hs_a - h0), 128'd64);
        check("frame_done_pulses", 128'(dn_a - d0), 128'd1);
        check("frame_queues_empty", 128'(ew_a.size() + ea_a.size()), 128'd0);
        check("idle_after_frame", 128'({busy_a, wv_a}), 128'd0);

        // Reset during EMIT of channel 2, then a clean restart.
        push_frame(18, 1'b0);
        pulse_start(1'b0);
        wait_a(2, -1);
        check("reached_ch2", 128'({wv_a, wch_a}), 128'({1'b1, 2'd2}));
        rst_n = 1'b0;
        #1 check("midframe_reset_outputs",
                 128'({rd_a, addr_a, wv_a, wd_a, wch_a, wcol_a, busy_a, done_a}), 128'd0);
        ew_a.delete();
        ea_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 check("no_read_without_start", 128'({busy_a, rd_a}), 128'd0);
        push_frame(18, 1'b0);
        d0 = dn_a;
        h0 = hs_a;
        pulse_start(1'b0);
        wait_a(0, -1);
        check("restart_first_pos", 128'({wv_a, wch_a, wcol_a}), 128'({1'b1, 2'd0, 5'd0}));
        wait_done(1'b0, d0);
        check("restart_windows", 128'(hs_a - h0), 128'd64);
        check("restart_done_pulses", 128'(dn_a - d0), 128'd1);

        // COLS=33 instance.
        push_frame(33, 1'b1);
        d0 = dn_b;
        h0 = hs_b;
        pulse_start(1'b1);
        t = 0;
        while (!(wv_b && wcol_b == 6'd30) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("b_col30_data", 128'(wd_b), 128'(72'h201F1E201F1E201F1E));
        wait_done(1'b1, d0);
        check("b_windows", 128'(hs_b - h0), 128'd124);
        check("b_done_pulses", 128'(dn_b - d0), 128'd1);
        check("b_queues_empty", 128'(ew_b.size() + ea_b.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
